// File: rtl/unidade_controle.sv
// Instruction sequencer driving the X/Y/Z register control codes and the ALU select.
// Define CU_ILLEGAL_OP_EN to add the erro port, which pulses for opcodes 6-7.
`timescale 1ns/1ps

module unidade_controle #(
    parameter logic [3:0] CLEAR  = 4'd0,
    parameter logic [3:0] LOAD   = 4'd1,
    parameter logic [3:0] HOLD   = 4'd2,
    parameter logic [3:0] SHIFTR = 4'd3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [3:0] valor,
    output logic [3:0] entrada,
    output logic [3:0] tx,
    output logic [3:0] ty,
    output logic [3:0] tz,
    output logic [1:0] sel_ula,
    output logic       busy,
    output logic       done
`ifdef CU_ILLEGAL_OP_EN
    ,
    output logic       erro
`endif
);

    localparam logic [2:0] INIT   = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0] state, next_state;
    logic [2:0] op_q;
    logic [3:0] valor_q;

    logic [3:0] tx_d, ty_d, tz_d, entrada_d;
    logic [1:0] sel_d;
    logic       busy_d, done_d;
`ifdef CU_ILLEGAL_OP_EN
    logic       erro_d;
`endif

    always_comb begin
        next_state = state;
        case (state)
            INIT:    next_state = IDLE;
            IDLE:    if (start) next_state = DECODE;
            DECODE:  next_state = EXEC;
            EXEC:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    // NOTE: outputs are decoded from next_state and then registered, so each
    // output flop already shows the value belonging to the state being entered.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        tx_d      = HOLD;
        ty_d      = HOLD;
        tz_d      = HOLD;
        sel_d     = 2'd0;
        entrada_d = entrada;
        busy_d    = (next_state != IDLE);
        done_d    = (next_state == DONE);
`ifdef CU_ILLEGAL_OP_EN
        erro_d    = 1'b0;
`endif
        case (next_state)
            INIT: begin
                tx_d = CLEAR;
                ty_d = CLEAR;
                tz_d = CLEAR;
            end
            EXEC: begin
                case (op_q)
                    3'd0: begin
                        tx_d = CLEAR;
                        ty_d = CLEAR;
                        tz_d = CLEAR;
                    end
                    3'd1: begin
                        tx_d      = LOAD;
                        entrada_d = valor_q;
                    end
                    3'd2: ty_d = LOAD;
                    3'd3: begin
                        tz_d  = LOAD;
                        sel_d = 2'd1;
                    end
                    3'd4: begin
                        tz_d  = LOAD;
                        sel_d = 2'd2;
                    end
                    3'd5: tx_d = SHIFTR;
`ifdef CU_ILLEGAL_OP_EN
                    3'd6, 3'd7: erro_d = 1'b1;
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= INIT;
            op_q    <= 3'd0;
            valor_q <= 4'd0;
            tx      <= CLEAR;
            ty      <= CLEAR;
            tz      <= CLEAR;
            entrada <= 4'd0;
            sel_ula <= 2'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef CU_ILLEGAL_OP_EN
            erro    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                op_q    <= opcode;
                valor_q <= valor;
            end
            tx      <= tx_d;
            ty      <= ty_d;
            tz      <= tz_d;
            entrada <= entrada_d;
            sel_ula <= sel_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef CU_ILLEGAL_OP_EN
            erro    <= erro_d;
`endif
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle; inputs change and outputs are
// sampled on the falling clock edge. Build with CU_ILLEGAL_OP_EN to cover erro.
`timescale 1ns/1ps

module tb_unidade_controle;

    localparam logic [3:0] CLEAR  = 4'd0;
    localparam logic [3:0] LOAD   = 4'd1;
    localparam logic [3:0] HOLD   = 4'd2;
    localparam logic [3:0] SHIFTR = 4'd3;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [3:0] valor = 4'd0;
    logic [3:0] entrada, tx, ty, tz;
    logic [1:0] sel_ula;
    logic       busy, done;
`ifdef CU_ILLEGAL_OP_EN
    logic       erro;
`endif

    int checks = 0;
    int failures = 0;
    logic [3:0] ent_exp = 4'd0;

    unidade_controle dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .opcode  (opcode),
        .valor   (valor),
        .entrada (entrada),
        .tx      (tx),
        .ty      (ty),
        .tz      (tz),
        .sel_ula (sel_ula),
        .busy    (busy),
        .done    (done)
`ifdef CU_ILLEGAL_OP_EN
        ,
        .erro    (erro)
`endif
    );

    always #5 clock = ~clock;

    // Observed bundle: {tx, ty, tz, sel_ula, entrada, busy, done}
    wire [19:0] obs = {tx, ty, tz, sel_ula, entrada, busy, done};

    function automatic logic [19:0] vec(input logic [3:0] x, input logic [3:0] y,
                                        input logic [3:0] z, input logic [1:0] s,
                                        input logic [3:0] e, input logic b, input logic d);
        return {x, y, z, s, e, b, d};
    endfunction

    task automatic launch(input logic [2:0] op, input logic [3:0] v);
        start = 1'b1; opcode = op; valor = v;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [19:0] exp;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        exp = vec(CLEAR, CLEAR, CLEAR, 2'd0, 4'd0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp); end
        resetn = 1'b1;
        #1;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL init_cycle got=%h exp=%h", obs, exp); end
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL idle_after_init got=%h exp=%h", obs, exp); end
        ent_exp = 4'd0;
    endtask

    task automatic test_ldx;
        logic [19:0] exp;
        launch(3'd1, 4'hA);
        opcode = 3'd2; valor = 4'h5;
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL ldx_decode got=%h exp=%h", obs, exp); end
        @(negedge clock);
        ent_exp = 4'hA;
        exp = vec(LOAD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL ldx_exec got=%h exp=%h", obs, exp); end
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL ldx_done got=%h exp=%h", obs, exp); end
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL ldx_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_back_to_back;
        logic [19:0] exp;
        start = 1'b1; opcode = 3'd3; valor = 4'h1;
        @(negedge clock);
        opcode = 3'd4;
        @(negedge clock);
        exp = vec(HOLD, HOLD, LOAD, 2'd1, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_add_exec got=%h exp=%h", obs, exp); end
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_add_done got=%h exp=%h", obs, exp); end
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", obs, exp); end
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_sub_decode got=%h exp=%h", obs, exp); end
        @(negedge clock);
        start = 1'b0;
        exp = vec(HOLD, HOLD, LOAD, 2'd2, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_sub_exec got=%h exp=%h", obs, exp); end
        repeat (2) @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_final_idle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_ignore_busy;
        logic [19:0] exp;
        launch(3'd5, 4'h3);
        start = 1'b1; opcode = 3'd0; valor = 4'hF;
        @(negedge clock);
        start = 1'b0;
        exp = vec(SHIFTR, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL shr_exec got=%h exp=%h", obs, exp); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, (i == 0), (i == 0));
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL no_clear_after_shr[%0d] got=%h exp=%h", i, obs, exp); end
        end
    endtask

    task automatic test_opcodes;
        logic [19:0] exp;
        logic [3:0]  v;
        for (int op = 0; op < 8; op++) begin
            v = 4'(op + 3);
            launch(3'(op), v);
            exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL op%0d_decode got=%h exp=%h", op, obs, exp); end
            @(negedge clock);
            case (op)
                0: exp = vec(CLEAR, CLEAR, CLEAR, 2'd0, ent_exp, 1'b1, 1'b0);
                1: begin ent_exp = v; exp = vec(LOAD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0); end
                2: exp = vec(HOLD, LOAD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
                3: exp = vec(HOLD, HOLD, LOAD, 2'd1, ent_exp, 1'b1, 1'b0);
                4: exp = vec(HOLD, HOLD, LOAD, 2'd2, ent_exp, 1'b1, 1'b0);
                5: exp = vec(SHIFTR, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
                default: exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b0);
            endcase
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL op%0d_exec got=%h exp=%h", op, obs, exp); end
`ifdef CU_ILLEGAL_OP_EN
            checks++;
            if (erro !== (op >= 6)) begin failures++; $display("FAIL op%0d_erro_exec got=%b exp=%b", op, erro, (op >= 6)); end
`endif
            @(negedge clock);
            exp = vec(HOLD, HOLD, HOLD, 2'd0, ent_exp, 1'b1, 1'b1);
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL op%0d_done got=%h exp=%h", op, obs, exp); end
`ifdef CU_ILLEGAL_OP_EN
            checks++;
            if (erro !== 1'b0) begin failures++; $display("FAIL op%0d_erro_done got=%b exp=0", op, erro); end
`endif
            @(negedge clock);
        end
    endtask

    task automatic test_reset_abort;
        logic [19:0] exp;
        launch(3'd3, 4'h6);
        @(negedge clock);
        exp = vec(HOLD, HOLD, LOAD, 2'd1, ent_exp, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL abort_exec got=%h exp=%h", obs, exp); end
        #2 resetn = 1'b0;
        #1;
        ent_exp = 4'd0;
        exp = vec(CLEAR, CLEAR, CLEAR, 2'd0, 4'd0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL abort_immediate got=%h exp=%h", obs, exp); end
        @(negedge clock);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL abort_no_done got=%h exp=%h", obs, exp); end
        resetn = 1'b1;
        @(negedge clock);
        exp = vec(HOLD, HOLD, HOLD, 2'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL abort_recover got=%h exp=%h", obs, exp); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ldx();
        test_back_to_back();
        test_ignore_busy();
        test_opcodes();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter CLEAR, default 4'd0, register control code: clear.
REQ-002 Parameter LOAD, default 4'd1, register control code: load.
REQ-003 Parameter HOLD, default 4'd2, register control code: hold.
REQ-004 Parameter SHIFTR, default 4'd3, register control code: shift right.
REQ-005 clock  input  1  single clock for the block; all state changes on the rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-008 opcode  input  3  instruction code; latched with start.
REQ-009 valor  input  4  immediate operand; latched with start.
REQ-010 entrada  output  4  data presented to register X's load input.
REQ-011 tx, ty, tz  output  4 each  control codes for registers X, Y, Z.
REQ-012 sel_ula  output  2  ALU select: 0 pass, 1 add, 2 sub.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 erro  output  1  illegal-opcode pulse; present only when CU_ILLEGAL_OP_EN is defined.

Function
REQ-016 The block SHALL be a Moore FSM with states INIT, IDLE, DECODE, EXEC, DONE; all outputs SHALL be registered.
REQ-017 INIT: tx=ty=tz=CLEAR for exactly one cycle, then IDLE.
REQ-018 IDLE: tx=ty=tz=HOLD, busy=0; on start=1, latch opcode and valor and go to DECODE.
REQ-019 DECODE: one cycle, codes HOLD, busy=1, then EXEC.
REQ-020 EXEC: one cycle, codes per latched opcode, then DONE.
REQ-021 Opcode 0 CLR: tx=ty=tz=CLEAR.
REQ-022 Opcode 1 LDX: tx=LOAD, entrada=latched valor.
REQ-023 Opcode 2 MOVY: ty=LOAD.
REQ-024 Opcode 3 ADD: tz=LOAD, sel_ula=1.
REQ-025 Opcode 4 SUB: tz=LOAD, sel_ula=2.
REQ-026 Opcode 5 SHR: tx=SHIFTR.
REQ-027 Opcodes 6-7: all codes HOLD (NOP).
REQ-028 Unused codes in EXEC SHALL be HOLD; sel_ula SHALL be 0 and entrada SHALL hold its last value outside EXEC.
REQ-029 DONE: done=1 for one cycle, codes HOLD, then IDLE; start-to-done latency is exactly 3 cycles.
REQ-030 start while busy=1 SHALL be ignored; the opcode and valor latches SHALL not change.
REQ-031 start held high continuously SHALL launch a new instruction every 4 cycles: IDLE, DECODE, EXEC, DONE.

Reset
REQ-032 While resetn=0: state=INIT, tx=ty=tz=CLEAR, entrada=0, sel_ula=0, busy=1, done=0, erro=0.
REQ-033 Reset assertion mid-instruction SHALL abort it immediately; no EXEC codes or done pulse are emitted for the aborted instruction.
REQ-034 After resetn deasserts, the FSM SHALL spend one cycle in INIT before IDLE.

Configuration
REQ-035 With CU_ILLEGAL_OP_EN defined, opcodes 6-7 SHALL pulse erro=1 in the EXEC cycle; done SHALL still pulse in the following cycle.
REQ-036 Without CU_ILLEGAL_OP_EN, the erro port and its logic SHALL be absent, and opcodes 6-7 SHALL be silent NOPs.

Verification
REQ-037 Release reset, then wait 1 cycle -> tx=ty=tz=CLEAR in INIT, then HOLD with busy=0.
REQ-038 start=1, opcode=1, valor=4'hA -> after 2 cycles, tx=LOAD and entrada=4'hA for one cycle; done=1 on the 3rd cycle.
REQ-039 Issue ADD, then SUB back-to-back -> tz=LOAD with sel_ula=1, then 4 cycles later tz=LOAD with sel_ula=2.
REQ-040 Issue opcode 5, then pulse start=1 with opcode=0 during DECODE -> only tx=SHIFTR is issued and no CLEAR follows.
REQ-041 Assert resetn=0 during EXEC of opcode 3 -> tz=CLEAR immediately and no done pulse occurs.
REQ-042 Issue opcode 7 with the macro defined -> erro=1 in EXEC; without the macro, codes stay HOLD and done=1.
